// File: rtl/axis_pattern_tx.sv
// axis_pattern_tx: stream master that emits framed packets of an incrementing payload.
// data_o[DATA_WIDTH-1] flags the last beat of each packet; the lower bits carry the payload.
// Optional feature: define AXIS_TX_THROTTLE_EN to insert LFSR-driven bubbles before new beats.
module axis_pattern_tx #(
  parameter int DATA_WIDTH = 9,
  parameter int LEN_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  pkt_len_i,
  input  logic [CNT_WIDTH-1:0]  num_pkts_i,
  input  logic [DATA_WIDTH-2:0] seed_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_WIDTH-1:0]  pkt_cnt_o
);

  localparam int PW = DATA_WIDTH - 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t                state_q, state_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [CNT_WIDTH-1:0]  num_q, num_d;
  logic [PW-1:0]         pay_q, pay_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  bubble;

`ifdef AXIS_TX_THROTTLE_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Free-running x^8+x^6+x^5+x^4+1 Fibonacci LFSR; bit 0 requests a bubble
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    bubble = lfsr_q[0];
  end

  // LFSR state register
  always_ff @(posedge aclk) begin
    if (areset) lfsr_q <= 8'hA5;
    else        lfsr_q <= lfsr_d;
  end
`else
  // No throttling: a new beat is always presented as soon as possible
  always_comb bubble = 1'b0;
`endif

  // Next-state logic: beats are loaded into the output register only when a "present" is requested
  always_comb begin
    logic xfer, last_pkt, eop_next, present;
    state_d   = state_q;
    valid_d   = valid_q;
    data_d    = data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pkt_cnt_d = pkt_cnt_q;
    len_d     = len_q;
    num_d     = num_q;
    pay_d     = pay_q;
    beat_d    = beat_q;
    gap_d     = gap_q;
    present   = 1'b0;
    xfer      = valid_q && ready_o;
    last_pkt  = (pkt_cnt_q + 1'b1) == num_q;
    eop_next  = beat_q == (len_q - 1'b1);
    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        if (start_i) begin
          len_d     = pkt_len_i;
          num_d     = num_pkts_i;
          pay_d     = seed_i;
          beat_d    = '0;
          pkt_cnt_d = '0;
          if (pkt_len_i != '0 && num_pkts_i != '0) begin
            state_d = S_SEND;
            busy_d  = 1'b1;
          end else begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      S_SEND: begin
        if (xfer) begin
          if (data_q[DATA_WIDTH-1]) begin
            pkt_cnt_d = pkt_cnt_q + 1'b1;
            if (last_pkt) begin
              state_d = S_DONE;
              valid_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else if (GAP_CYCLES == 0) begin
              present = 1'b1;
            end else begin
              state_d = S_GAP;
              valid_d = 1'b0;
              gap_d   = '0;
            end
          end else begin
            present = 1'b1;
          end
        end else if (!valid_q) begin
          present = 1'b1;
        end
      end
      S_GAP: begin
        // The final gap cycle already loads the next beat so the idle count is exact
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          state_d = S_SEND;
          present = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (present) begin
      if (bubble) begin
        valid_d = 1'b0;
      end else begin
        valid_d = 1'b1;
        data_d  = {eop_next, pay_q};
        pay_d   = pay_q + 1'b1;
        beat_d  = eop_next ? '0 : beat_q + 1'b1;
      end
    end
  end

  // State and registered outputs; reset aborts any run in progress
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= S_IDLE;
      valid_q   <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pkt_cnt_q <= '0;
      len_q     <= '0;
      num_q     <= '0;
      pay_q     <= '0;
      beat_q    <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pkt_cnt_q <= pkt_cnt_d;
      len_q     <= len_d;
      num_q     <= num_d;
      pay_q     <= pay_d;
      beat_q    <= beat_d;
      gap_q     <= gap_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign pkt_cnt_o = pkt_cnt_q;

endmodule

// File: tb/tb_axis_pattern_tx.sv
// Testbench for axis_pattern_tx: scoreboard of expected beats checked by a monitor on each transfer.
module tb_axis_pattern_tx;

  logic        aclk = 1'b0;
  logic        areset;
  logic        start_i;
  logic [7:0]  pkt_len_i;
  logic [15:0] num_pkts_i;
  logic [7:0]  seed_i;
  logic [8:0]  data_o;
  logic        valid_o;
  logic        ready_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] pkt_cnt_o;

  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         n_xfer = 0;
  bit         rec = 0;
  bit         held = 0;
  logic [8:0] held_data;
  logic [8:0] expq[$];
  int         xcyc[$];

  axis_pattern_tx #(.DATA_WIDTH(9), .LEN_WIDTH(8), .CNT_WIDTH(16), .GAP_CYCLES(2)) dut (
    .aclk(aclk), .areset(areset), .start_i(start_i), .pkt_len_i(pkt_len_i),
    .num_pkts_i(num_pkts_i), .seed_i(seed_i), .data_o(data_o), .valid_o(valid_o),
    .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o), .pkt_cnt_o(pkt_cnt_o)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every transfer and checks stall stability
  always @(negedge aclk) begin
    if (areset) begin
      held = 0;
    end else begin
      if (held) begin
        chk("hold_valid", {31'd0, valid_o}, 32'd1);
        chk("hold_data", {23'd0, data_o}, {23'd0, held_data});
      end
      if (valid_o && ready_o) begin
        n_xfer++;
        if (rec) xcyc.push_back(cyc);
        if (expq.size() == 0) begin
          chk("unexpected_beat", {23'd0, data_o}, 32'h1FF);
        end else begin
          chk("beat", {23'd0, data_o}, {23'd0, expq.pop_front()});
        end
      end
      held = valid_o && !ready_o;
      held_data = data_o;
    end
  end

  task automatic start_run(input logic [7:0] len, input logic [15:0] num, input logic [7:0] seed);
    @(posedge aclk) #1;
    start_i = 1'b1; pkt_len_i = len; num_pkts_i = num; seed_i = seed;
    @(posedge aclk) #1;
    start_i = 1'b0;
  endtask

  task automatic push_model(input int len, input int num, input logic [7:0] seed);
    logic [7:0] p;
    p = seed;
    for (int k = 0; k < len * num; k++) begin
      expq.push_back({(k % len) == len - 1, p});
      p = p + 8'd1;
    end
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge aclk);
      if (done_o) begin seen = 1; break; end
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
  endtask

  logic [8:0] v1[12] = '{9'h010, 9'h011, 9'h012, 9'h113, 9'h014, 9'h015,
                         9'h016, 9'h117, 9'h018, 9'h019, 9'h01A, 9'h11B};
  logic [8:0] v2[4]  = '{9'h0FE, 9'h0FF, 9'h000, 9'h101};
  logic       pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    areset = 1'b1; start_i = 1'b0; pkt_len_i = '0; num_pkts_i = '0; seed_i = '0; ready_o = 1'b1;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_data", {23'd0, data_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_pkt_cnt", {16'd0, pkt_cnt_o}, 32'd0);

    // Test 1: three packets of four beats, gaps between packets, start ignored while busy
    foreach (v1[i]) expq.push_back(v1[i]);
    xcyc.delete(); rec = 1;
    start_run(8'd4, 16'd3, 8'h10);
    @(negedge aclk);
    chk("t1_latency_low", {31'd0, valid_o}, 32'd0);
    chk("t1_busy", {31'd0, busy_o}, 32'd1);
    @(negedge aclk);
    chk("t1_latency_high", {31'd0, valid_o}, 32'd1);
    chk("t1_first_data", {23'd0, data_o}, 32'h010);
    @(posedge aclk) #1;
    start_i = 1'b1; pkt_len_i = 8'd1; num_pkts_i = 16'd1; seed_i = 8'h77;
    @(posedge aclk) #1;
    start_i = 1'b0;
    wait_done(200);
    chk("t1_done_busy", {31'd0, busy_o}, 32'd0);
    chk("t1_pkt_cnt", {16'd0, pkt_cnt_o}, 32'd3);
    @(negedge aclk);
    chk("t1_done_pulse", {31'd0, done_o}, 32'd0);
    rec = 0;
    chk("t1_xfer_count", xcyc.size(), 32'd12);
    if (xcyc.size() == 12) begin
      chk("t1_back_to_back", xcyc[1] - xcyc[0], 32'd1);
      chk("t1_gap1", xcyc[4] - xcyc[3], 32'd3);
      chk("t1_gap2", xcyc[8] - xcyc[7], 32'd3);
    end

    // Test 2: payload wraps, end-of-packet flag only on the last beat
    chk("t2_cnt_hold", {16'd0, pkt_cnt_o}, 32'd3);
    foreach (v2[i]) expq.push_back(v2[i]);
    start_run(8'd4, 16'd1, 8'hFE);
    @(negedge aclk);
    chk("t2_cnt_clear", {16'd0, pkt_cnt_o}, 32'd0);
    wait_done(100);
    chk("t2_pkt_cnt", {16'd0, pkt_cnt_o}, 32'd1);

    // Test 3: ready toggling 1,0,0,1; beats must hold and never be lost or repeated
    push_model(5, 1, 8'h30);
    start_run(8'd5, 16'd1, 8'h30);
    for (int i = 0; i < 200; i++) begin
      @(posedge aclk) #1;
      ready_o = pat[i % 4];
      if (done_o) break;
    end
    ready_o = 1'b1;
    chk("t3_pkt_cnt", {16'd0, pkt_cnt_o}, 32'd1);
    chk("t3_queue_empty", expq.size(), 32'd0);

    // Test 4: downstream accepts eight beats then stalls; ninth beat must wait on the bus
    push_model(12, 1, 8'h40);
    n_xfer = 0;
    start_run(8'd12, 16'd1, 8'h40);
    for (int i = 0; i < 100; i++) begin
      @(posedge aclk) #1;
      if (n_xfer >= 8) break;
    end
    ready_o = 1'b0;
    repeat (10) @(posedge aclk);
    @(negedge aclk);
    chk("t4_stall_valid", {31'd0, valid_o}, 32'd1);
    chk("t4_stall_data", {23'd0, data_o}, 32'h048);
    @(posedge aclk) #1 ready_o = 1'b1;
    wait_done(100);
    chk("t4_pkt_cnt", {16'd0, pkt_cnt_o}, 32'd1);
    chk("t4_queue_empty", expq.size(), 32'd0);

    // Test 5: reset in the middle of packet 2, then a clean run
    push_model(4, 3, 8'h20);
    start_run(8'd4, 16'd3, 8'h20);
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (pkt_cnt_o == 16'd1) break;
    end
    chk("t5_first_pkt", {16'd0, pkt_cnt_o}, 32'd1);
    repeat (4) @(posedge aclk);
    #1 ready_o = 1'b0;
    @(posedge aclk) #1 areset = 1'b1;
    @(posedge aclk) #1 areset = 1'b0;
    @(negedge aclk);
    chk("t5_valid", {31'd0, valid_o}, 32'd0);
    chk("t5_busy", {31'd0, busy_o}, 32'd0);
    chk("t5_pkt_cnt", {16'd0, pkt_cnt_o}, 32'd0);
    chk("t5_data", {23'd0, data_o}, 32'd0);
    expq.delete();
    ready_o = 1'b1;
    push_model(2, 2, 8'h05);
    start_run(8'd2, 16'd2, 8'h05);
    wait_done(100);
    chk("t5_rerun_cnt", {16'd0, pkt_cnt_o}, 32'd2);

    // Test 6: zero-length packet produces no beats and an immediate done
    start_run(8'd0, 16'd5, 8'h33);
    @(negedge aclk);
    chk("t6_done", {31'd0, done_o}, 32'd1);
    chk("t6_valid", {31'd0, valid_o}, 32'd0);
    chk("t6_busy", {31'd0, busy_o}, 32'd0);
    @(negedge aclk);
    chk("t6_done_pulse", {31'd0, done_o}, 32'd0);
    chk("t6_valid2", {31'd0, valid_o}, 32'd0);
    repeat (3) @(negedge aclk);
    chk("final_queue_empty", expq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
